// File: rtl/mcp3202_scan_scheduler.sv
// Scan scheduler for an MCP3202 SPI engine: sample tick, per-channel command issue,
// response capture, signed conversion and a 2-entry AXI-Stream output buffer.
module mcp3202_scan_scheduler #(
  parameter int unsigned FCLK        = 100_000_000,
  parameter int unsigned FSMPL       = 500,
  parameter logic [1:0]  CH_MASK     = 2'b11,
  parameter bit          SGL         = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_sgl,
  output logic        cmd_odd,
  input  logic        rsp_valid,
  input  logic [11:0] rsp_data,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tid,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] overrun_cnt,
  output logic [15:0] miss_cnt,
  output logic        err_timeout
);

  localparam int unsigned DIV   = FCLK / FSMPL;
  localparam int          DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int          TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic FIRST_CH = CH_MASK[0] ? 1'b0 : 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ISSUE,
    WAIT_RSP,
    PUSH
  } state_t;

  state_t            state_reg;
  logic [DIV_W-1:0]  tick_cnt_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic              ch_reg;
  logic [11:0]       code_reg;
  logic              cmd_valid_reg;
  logic              cmd_sgl_reg;
  logic              cmd_odd_reg;
  logic [15:0]       miss_cnt_reg;
  logic              err_timeout_reg;
  logic              tick;
  logic              more_ch;
  logic              scan_busy;

  assign tick      = (tick_cnt_reg == DIV_LAST);
  assign more_ch   = (ch_reg == 1'b0) && CH_MASK[1];
  assign scan_busy = (state_reg == ISSUE) || (state_reg == WAIT_RSP) || (state_reg == PUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg <= '0;
    end else if (!en || tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      to_cnt_reg      <= '0;
      ch_reg          <= 1'b0;
      code_reg        <= '0;
      cmd_valid_reg   <= 1'b0;
      cmd_sgl_reg     <= 1'b0;
      cmd_odd_reg     <= 1'b0;
      miss_cnt_reg    <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      // A tick that lands on an active scan is dropped, not queued.
      if (tick && scan_busy && (miss_cnt_reg != 16'hFFFF)) begin
        miss_cnt_reg <= miss_cnt_reg + 16'd1;
      end
      case (state_reg)
        IDLE: begin
          if (en) state_reg <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (!en) begin
            state_reg <= IDLE;
          end else if (tick) begin
            ch_reg        <= FIRST_CH;
            cmd_valid_reg <= 1'b1;
            cmd_odd_reg   <= FIRST_CH;
            cmd_sgl_reg   <= SGL;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_reg <= 1'b0;
            to_cnt_reg    <= '0;
            state_reg     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_valid) begin
            code_reg  <= rsp_data;
            state_reg <= PUSH;
          end else if (to_cnt_reg == TO_LAST) begin
            err_timeout_reg <= 1'b1;
            state_reg       <= en ? WAIT_TICK : IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        PUSH: begin
          if (more_ch && en) begin
            ch_reg        <= 1'b1;
            cmd_valid_reg <= 1'b1;
            cmd_odd_reg   <= 1'b1;
            cmd_sgl_reg   <= SGL;
            state_reg     <= ISSUE;
          end else begin
            state_reg <= en ? WAIT_TICK : IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_reg;
  assign cmd_sgl     = cmd_sgl_reg;
  assign cmd_odd     = cmd_odd_reg;
  assign miss_cnt    = miss_cnt_reg;
  assign err_timeout = err_timeout_reg;

  // Two-entry output buffer; a write into a full buffer is allowed when the head pops the same cycle.
  logic [15:0] mem_tdata_reg [2];
  logic        mem_tid_reg   [2];
  logic        mem_tlast_reg [2];
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  count_reg;
  logic [15:0] overrun_cnt_reg;
  logic        push;
  logic        pop;
  logic        push_ok;
  logic [15:0] push_tdata;

  assign push       = (state_reg == PUSH);
  assign pop        = (count_reg != 2'd0) && m_axis_tready;
  assign push_ok    = push && ((count_reg != 2'd2) || pop);
  assign push_tdata = {4'b0000, code_reg} - 16'd2048;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_tdata_reg[gi] <= '0;
          mem_tid_reg[gi]   <= 1'b0;
          mem_tlast_reg[gi] <= 1'b0;
        end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
          mem_tdata_reg[gi] <= push_tdata;
          mem_tid_reg[gi]   <= ch_reg;
          mem_tlast_reg[gi] <= !more_ch;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
      count_reg       <= 2'd0;
      overrun_cnt_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)     rd_ptr_reg <= ~rd_ptr_reg;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
      if (push && !push_ok && (overrun_cnt_reg != 16'hFFFF)) begin
        overrun_cnt_reg <= overrun_cnt_reg + 16'd1;
      end
    end
  end

  assign m_axis_tvalid = (count_reg != 2'd0);
  assign m_axis_tdata  = mem_tdata_reg[rd_ptr_reg];
  assign m_axis_tid    = mem_tid_reg[rd_ptr_reg];
  assign m_axis_tlast  = mem_tlast_reg[rd_ptr_reg];
  assign overrun_cnt   = overrun_cnt_reg;

endmodule

// File: tb/tb_mcp3202_scan_scheduler.sv
// Directed bench for mcp3202_scan_scheduler: ADC/engine models feed a scoreboard queue
// that is checked against every AXI-Stream beat. A second instance covers CH_MASK=10.
module tb_mcp3202_scan_scheduler;

  localparam int TIMEOUT = 4096;
  localparam int RSP_DLY = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rst_b_n = 1'b1;
  logic en = 1'b0, en_b = 1'b0;
  logic cmd_ready = 1'b1, cmd_ready_b = 1'b1;
  logic rsp_valid = 1'b0, rsp_valid_b = 1'b0;
  logic [11:0] rsp_data = '0, rsp_data_b = '0;
  logic m_tready = 1'b1, m_tready_b = 1'b1;

  logic cmd_valid, cmd_sgl, cmd_odd, tvalid, tid, tlast, err_timeout;
  logic [15:0] tdata, overrun_cnt, miss_cnt;
  logic cmd_valid_b, cmd_sgl_b, cmd_odd_b, tvalid_b, tid_b, tlast_b, err_timeout_b;
  logic [15:0] tdata_b, overrun_cnt_b, miss_cnt_b;

  int checks = 0, failures = 0;
  int cyc = 0, beat_cnt = 0, resp_cnt = 0, beats_b = 0;
  int last_acc_cyc = 0, last_rsp_cyc = 0, prev_ch0_cyc = -1;
  bit adc_mute = 1'b0, spacing_chk = 1'b0, lat_chk = 1'b0;
  logic [11:0] code_tab [2];
  logic [15:0] exp_tab  [2];
  logic [17:0] exp_q  [$];
  logic [17:0] exp_qb [$];

  mcp3202_scan_scheduler #(.FCLK(1_000_000), .FSMPL(1000), .CH_MASK(2'b11), .SGL(1'b1),
                           .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sgl(cmd_sgl), .cmd_odd(cmd_odd), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .m_axis_tdata(tdata), .m_axis_tid(tid), .m_axis_tlast(tlast), .m_axis_tvalid(tvalid),
    .m_axis_tready(m_tready), .overrun_cnt(overrun_cnt), .miss_cnt(miss_cnt),
    .err_timeout(err_timeout));

  mcp3202_scan_scheduler #(.FCLK(1_000_000), .FSMPL(2000), .CH_MASK(2'b10), .SGL(1'b1),
                           .TIMEOUT_CYC(TIMEOUT)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .en(en_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_sgl(cmd_sgl_b), .cmd_odd(cmd_odd_b), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
    .m_axis_tdata(tdata_b), .m_axis_tid(tid_b), .m_axis_tlast(tlast_b), .m_axis_tvalid(tvalid_b),
    .m_axis_tready(m_tready_b), .overrun_cnt(overrun_cnt_b), .miss_cnt(miss_cnt_b),
    .err_timeout(err_timeout_b));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_codes(input logic [11:0] c0, input logic [15:0] e0,
                           input logic [11:0] c1, input logic [15:0] e1);
    code_tab[0] = c0; exp_tab[0] = e0;
    code_tab[1] = c1; exp_tab[1] = e1;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int target = beat_cnt + n;
    int k = 0;
    while (beat_cnt < target && k < budget) begin @(negedge clk); k++; end
    chk(tag, 32'(beat_cnt >= target), 1);
  endtask

  task automatic wait_resp(input int n, input int budget, input string tag);
    int target = resp_cnt + n;
    int k = 0;
    while (resp_cnt < target && k < budget) begin @(negedge clk); k++; end
    chk(tag, 32'(resp_cnt >= target), 1);
  endtask

  task automatic wait_cmd_valid(input logic v, input int budget, input string tag);
    int k = 0;
    @(negedge clk);
    while (cmd_valid !== v && k < budget) begin @(negedge clk); k++; end
    chk(tag, 32'(cmd_valid), 32'(v));
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_cmd_valid"}, 32'(cmd_valid), 0);
    chk({pfx, "_cmd_sgl"}, 32'(cmd_sgl), 0);
    chk({pfx, "_cmd_odd"}, 32'(cmd_odd), 0);
    chk({pfx, "_tvalid"}, 32'(tvalid), 0);
    chk({pfx, "_tdata"}, 32'(tdata), 0);
    chk({pfx, "_tid_tlast"}, 32'({tid, tlast}), 0);
    chk({pfx, "_overrun"}, 32'(overrun_cnt), 0);
    chk({pfx, "_miss"}, 32'(miss_cnt), 0);
    chk({pfx, "_err"}, 32'(err_timeout), 0);
  endtask

  // ADC/engine model: answers each accepted command RSP_DLY cycles later and scores the result.
  initial begin
    logic ch_l;
    forever begin
      @(negedge clk); #1;
      if (rst_n && cmd_valid && cmd_ready) begin
        ch_l = cmd_odd;
        last_acc_cyc = cyc;
        if (!ch_l) begin
          if (spacing_chk && prev_ch0_cyc >= 0) chk("tick_spacing", 32'(cyc - prev_ch0_cyc), 1000);
          prev_ch0_cyc = cyc;
        end
        if (!adc_mute) begin
          repeat (RSP_DLY) begin @(negedge clk); #1; end
          rsp_valid = 1'b1;
          rsp_data = code_tab[ch_l];
          last_rsp_cyc = cyc;
          if (exp_q.size() < 2) exp_q.push_back({exp_tab[ch_l], ch_l, ch_l});
          resp_cnt++;
          @(negedge clk); #1;
          rsp_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk); #1;
      if (rst_n && tvalid && m_tready) begin
        if (lat_chk) begin
          chk("rsp_to_tvalid_latency", 32'(cyc - last_rsp_cyc), 2);
          lat_chk = 1'b0;
        end
        chk("beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_data_tid_tlast", 32'({tdata, tid, tlast}), 32'(e));
        end
        beat_cnt++;
        $display("beat %0d cyc=%0d tid=%0d tdata=0x%04h tlast=%0d", beat_cnt, cyc, tid, tdata, tlast);
      end
    end
  end

  // Single-channel instance (CH_MASK=10): every command is channel 1, every beat tid=1 tlast=1.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst_b_n && cmd_valid_b && cmd_ready_b) begin
        chk("b_cmd_odd", 32'(cmd_odd_b), 1);
        chk("b_cmd_sgl", 32'(cmd_sgl_b), 1);
        repeat (RSP_DLY) begin @(negedge clk); #1; end
        rsp_valid_b = 1'b1;
        rsp_data_b = 12'h100;
        exp_qb.push_back({16'hF900, 1'b1, 1'b1});
        @(negedge clk); #1;
        rsp_valid_b = 1'b0;
      end
    end
  end

  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk); #1;
      if (rst_b_n && tvalid_b && m_tready_b) begin
        chk("b_beat_expected", 32'(exp_qb.size() != 0), 1);
        if (exp_qb.size() != 0) begin
          e = exp_qb.pop_front();
          chk("b_beat_data_tid_tlast", 32'({tdata_b, tid_b, tlast_b}), 32'(e));
        end
        beats_b++;
        $display("b_beat %0d cyc=%0d tid=%0d tdata=0x%04h tlast=%0d", beats_b, cyc, tid_b, tdata_b, tlast_b);
      end
    end
  end

  initial begin
    int base, k;
    bit stable, saw_cmd;
    logic [17:0] head;
    set_codes(12'hC00, 16'h0400, 12'h100, 16'hF900);
    #1;
    rst_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    rst_b_n = 1'b1;
    en_b = 1'b1;
    en = 1'b1;
    lat_chk = 1'b1;
    spacing_chk = 1'b1;

    // Three normal scans at full throughput.
    wait_beats(6, 3500, "normal_scans");
    spacing_chk = 1'b0;
    chk("normal_miss", 32'(miss_cnt), 0);
    chk("normal_overrun", 32'(overrun_cnt), 0);
    chk("normal_err", 32'(err_timeout), 0);

    // Backpressure over three scans: two results held, four dropped.
    m_tready = 1'b0;
    wait_resp(6, 3500, "stall_responses");
    repeat (5) @(negedge clk);
    chk("stall_overrun", 32'(overrun_cnt), 4);
    chk("stall_tvalid", 32'(tvalid), 1);
    head = (exp_q.size() != 0) ? exp_q[0] : 18'h0;
    chk("stall_head", 32'({tdata, tid, tlast}), 32'(head));
    repeat (200) @(negedge clk);
    chk("stall_head_stable", 32'({tdata, tid, tlast}), 32'(head));
    m_tready = 1'b1;
    wait_beats(2, 20, "stall_drain");
    wait_beats(2, 1100, "post_stall_scan");
    chk("post_stall_overrun", 32'(overrun_cnt), 4);

    // Conversion boundaries.
    set_codes(12'h000, 16'hF800, 12'h800, 16'h0000);
    wait_beats(2, 1100, "codes_min_mid");
    set_codes(12'hFFF, 16'h07FF, 12'hC00, 16'h0400);
    wait_beats(2, 1100, "codes_max");
    set_codes(12'hC00, 16'h0400, 12'h100, 16'hF900);

    // Silent ADC: timeout after TIMEOUT cycles, scan abandoned, resumes at the next tick.
    adc_mute = 1'b1;
    base = miss_cnt;
    k = 0;
    @(negedge clk);
    while (!err_timeout && k < 6000) begin @(negedge clk); k++; end
    chk("timeout_err_set", 32'(err_timeout), 1);
    // Accept stamp is taken half a cycle before the accept edge, hence the +1.
    chk("timeout_latency", 32'(cyc - last_acc_cyc), TIMEOUT + 1);
    adc_mute = 1'b0;
    chk("timeout_miss_delta", 32'(miss_cnt - base), 4);
    wait_beats(2, 2000, "timeout_resume");
    chk("timeout_err_sticky", 32'(err_timeout), 1);

    // Engine stalls cmd_ready for 1500 cycles; command fields must stay put.
    cmd_ready = 1'b0;
    wait_cmd_valid(1'b1, 1100, "hold_cmd_valid_rise");
    base = miss_cnt;
    stable = 1'b1;
    repeat (1500) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_odd !== 1'b0 || cmd_sgl !== 1'b1) stable = 1'b0;
    end
    chk("hold_cmd_stable", 32'(stable), 1);
    chk("hold_miss_delta", 32'(miss_cnt - base), 1);
    cmd_ready = 1'b1;
    wait_cmd_valid(1'b0, 5, "hold_accept");
    en = 1'b0;
    base = beat_cnt;
    saw_cmd = 1'b0;
    repeat (3000) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0) saw_cmd = 1'b1;
    end
    chk("en_off_no_cmd", 32'(saw_cmd), 0);
    chk("en_off_one_beat", 32'(beat_cnt - base), 1);

    // Asynchronous reset in the middle of a scan.
    en = 1'b1;
    cmd_ready = 1'b0;
    wait_cmd_valid(1'b1, 1100, "reset_mid_scan_issue");
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    wait_beats(2, 1200, "after_reset_scan");
    chk("after_reset_overrun", 32'(overrun_cnt), 0);
    chk("after_reset_miss", 32'(miss_cnt), 0);

    chk("b_beat_count", 32'(beats_b >= 10), 1);
    chk("b_overrun", 32'(overrun_cnt_b), 0);
    chk("b_err", 32'(err_timeout_b), 0);
    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
